// File: rtl/ucisc_pkg.sv
// Shared definitions for the uCISC step units: step/word widths and the
// destination-writer state encoding.
package ucisc_pkg;

  localparam int STEP_W = 2;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WRITE = 2'd1,
    INC       = 2'd2,
    ERROR     = 2'd3
  } dest_state_t;

endpackage

// File: rtl/dest_writer_if.sv
// Memory write bus between the destination writer (master) and memory (slave).
// A write is accepted on a rising edge where mem_write_en and mem_ready are both high.
interface dest_writer_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_data_out;
  logic             mem_write_en;
  logic             mem_ready;

  modport master (
    output mem_address,
    output mem_data_out,
    output mem_write_en,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_data_out,
    input  mem_write_en,
    output mem_ready
  );

endinterface

// File: rtl/dest_writer_bus_timeout.sv
// bus_timeout_counter: loadable down-counter for memory wait states.
// Loaded with LIMIT when a write starts and decremented on every wait edge.
// expire is high on the wait edge that uses up the last allowed cycle.
// LIMIT = 0 disables the timeout, so expire never rises.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  // next count: reload at write start, count down on wait edges, hold at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CW'(LIMIT);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // count register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (LIMIT != 0) && dec && (count_q == CW'(1));

endmodule

// File: rtl/dest_writer.sv
// dest_writer: commits the ALU result to the instruction destination.
// Register destinations get a one-cycle register-file strobe; memory
// destinations go through a ready/valid write with wait states, an optional
// post-increment of the destination register, and a wait-state timeout.
// Optional feature macro: DEST_WRITER_INCREMENT_EN (post-increment writeback).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for trigger; register writes complete from here
// MEM_WRITE | memory write requested, waiting for mem_ready, stall held
// INC       | one-cycle increment writeback of destination register
// ERROR     | write timed out; stall and bus_error held until reset
module dest_writer
  import ucisc_pkg::*;
#(
  parameter int          WIDTH      = WORD_W,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [STEP_W-1:0] step,
  input  logic [STEP_W-1:0] write_on,
  input  logic              dest_valid,
  input  logic              is_mem,
  input  logic [WIDTH-1:0]  immediate,
  input  logic [WIDTH-1:0]  dest_register_value,
  input  logic [WIDTH-1:0]  result,
  input  logic              increment,
  dest_writer_if.master     mem,
  output logic              reg_write_en,
  output logic [WIDTH-1:0]  reg_write_value,
  output logic              reg_inc_en,
  output logic [WIDTH-1:0]  reg_inc_value,
  output logic              stall,
  output logic              bus_error
);

`ifdef DEST_WRITER_INCREMENT_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  dest_state_t      state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] inc_q, inc_d;
  logic             inc_flag_q, inc_flag_d;
  logic             mem_we_q, mem_we_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_inc_en_q, reg_inc_en_d;
  logic             stall_q, stall_d;
  logic             bus_err_q, bus_err_d;

  logic trigger;
  logic wait_edge;
  logic expire;

  assign trigger   = dest_valid && (step == write_on) && (state_q == IDLE) && !done_q;
  assign wait_edge = (state_q == MEM_WRITE) && !mem.mem_ready;

  bus_timeout_counter #(
    .LIMIT (WAIT_LIMIT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (trigger && is_mem),
    .dec     (wait_edge),
    .expire  (expire)
  );

  // next-state and registered-output logic of the write sequencer
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    addr_d       = addr_q;
    data_d       = data_q;
    inc_d        = inc_q;
    inc_flag_d   = inc_flag_q;
    mem_we_d     = mem_we_q;
    reg_we_d     = 1'b0;
    reg_inc_en_d = 1'b0;
    stall_d      = stall_q;
    bus_err_d    = bus_err_q;

    // sequencer has moved past the write step: allow the next instruction
    if (step != write_on) begin
      done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          addr_d     = dest_register_value + immediate;
          data_d     = result;
          inc_d      = INC_EN ? (dest_register_value + WIDTH'(1)) : '0;
          inc_flag_d = increment && INC_EN;
          if (is_mem) begin
            state_d  = MEM_WRITE;
            mem_we_d = 1'b1;
            stall_d  = 1'b1;
          end else begin
            reg_we_d = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      MEM_WRITE: begin
        if (mem.mem_ready) begin
          mem_we_d = 1'b0;
          done_d   = 1'b1;
          if (inc_flag_q) begin
            state_d      = INC;
            reg_inc_en_d = 1'b1;
          end else begin
            state_d = IDLE;
            stall_d = 1'b0;
          end
        end else if (expire) begin
          state_d   = ERROR;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      INC: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset drops any pending write
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      inc_q        <= '0;
      inc_flag_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_inc_en_q <= 1'b0;
      stall_q      <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      inc_q        <= inc_d;
      inc_flag_q   <= inc_flag_d;
      mem_we_q     <= mem_we_d;
      reg_we_q     <= reg_we_d;
      reg_inc_en_q <= reg_inc_en_d;
      stall_q      <= stall_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem.mem_address  = addr_q;
  assign mem.mem_data_out = data_q;
  assign mem.mem_write_en = mem_we_q;
  assign reg_write_en     = reg_we_q;
  assign reg_write_value  = data_q;
  assign reg_inc_en       = reg_inc_en_q;
  assign reg_inc_value    = inc_q;
  assign stall            = stall_q;
  assign bus_error        = bus_err_q;

endmodule
